// File: rtl/vault_access_sequencer.sv
// Vault lock access controller: 4-digit code entry and compare, fail counting
// with timed lockout/alarm, timed auto-relock and code reprogramming while open.
module vault_access_sequencer #(
   parameter logic [15:0] RESET_CODE     = 16'h1234,
   parameter int          MAX_FAILS      = 3,
   parameter int          LOCKOUT_CYCLES = 1000,
   parameter int          OPEN_CYCLES    = 500,
   parameter int          ENTRY_TIMEOUT  = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] digit_in,
   input  logic       digit_vld,
   input  logic       clear,
   input  logic       prog_req,
   output logic       unlocked,
   output logic       lockout,
   output logic       alarm,
   output logic [2:0] digit_cnt,
   output logic [2:0] fail_cnt,
   output logic [2:0] state_code
);

   localparam int T_MAX = (LOCKOUT_CYCLES > OPEN_CYCLES)
                        ? ((LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT)
                        : ((OPEN_CYCLES > ENTRY_TIMEOUT) ? OPEN_CYCLES : ENTRY_TIMEOUT);
   localparam int TW = $clog2(T_MAX + 1);

   localparam logic [TW-1:0] T_ZERO        = {TW{1'b0}};
   localparam logic [TW-1:0] T_ONE         = TW'(1);
   localparam logic [TW-1:0] T_ALL1        = {TW{1'b1}};
   localparam logic [TW-1:0] ENTRY_LIMIT   = TW'(ENTRY_TIMEOUT - 1);
   localparam logic [TW-1:0] OPEN_LIMIT    = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] LOCKOUT_LIMIT = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [2:0]    FAIL_LIMIT    = 3'(MAX_FAILS);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_CHECK   = 3'd2,
      S_OPEN    = 3'd3,
      S_LOCKOUT = 3'd4,
      S_PROG    = 3'd5
   } state_t;

   state_t         state;
   logic [15:0]    code;
   logic [15:0]    entry;
   logic [TW-1:0]  timer;

   // New digits enter at the low nibble so the first digit ends up in [15:12].
   function automatic logic [15:0] shift_digit(input logic [15:0] cur, input logic [3:0] d);
      return {cur[11:0], d};
   endfunction

   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
      return (t == T_ALL1) ? t : t + T_ONE;
   endfunction

   assign state_code = state;

   // Main sequencer: state, code/entry registers, shared timer and all status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         code      <= RESET_CODE;
         entry     <= 16'h0000;
         digit_cnt <= 3'd0;
         fail_cnt  <= 3'd0;
         timer     <= T_ZERO;
         unlocked  <= 1'b0;
         lockout   <= 1'b0;
         alarm     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (digit_vld) begin
                  state     <= S_ENTRY;
                  entry     <= shift_digit(16'h0000, digit_in);
                  digit_cnt <= 3'd1;
                  timer     <= T_ZERO;
               end
            end

            // ENTRY and PROG collect digits identically; only the 4th digit differs.
            S_ENTRY, S_PROG: begin
               if (clear || (!digit_vld && (timer >= ENTRY_LIMIT))) begin
                  state     <= S_IDLE;
                  entry     <= 16'h0000;
                  digit_cnt <= 3'd0;
                  timer     <= T_ZERO;
                  unlocked  <= 1'b0;
               end else if (digit_vld) begin
                  timer <= T_ZERO;
                  if (digit_cnt != 3'd3) begin
                     entry     <= shift_digit(entry, digit_in);
                     digit_cnt <= digit_cnt + 3'd1;
                  end else if (state == S_ENTRY) begin
                     entry     <= shift_digit(entry, digit_in);
                     digit_cnt <= 3'd4;
                     state     <= S_CHECK;
                  end else begin
                     code      <= shift_digit(entry, digit_in);
                     entry     <= 16'h0000;
                     digit_cnt <= 3'd0;
                     state     <= S_IDLE;
                     unlocked  <= 1'b0;
                  end
               end else begin
                  timer <= sat_inc(timer);
               end
            end

            S_CHECK: begin
               entry     <= 16'h0000;
               digit_cnt <= 3'd0;
               timer     <= T_ZERO;
               if (entry == code) begin
                  state    <= S_OPEN;
                  unlocked <= 1'b1;
                  fail_cnt <= 3'd0;
               end else if ((fail_cnt + 3'd1) >= FAIL_LIMIT) begin
                  state    <= S_LOCKOUT;
                  lockout  <= 1'b1;
                  alarm    <= 1'b1;
                  fail_cnt <= FAIL_LIMIT;
               end else begin
                  state    <= S_IDLE;
                  fail_cnt <= fail_cnt + 3'd1;
               end
            end

            S_OPEN: begin
               if (clear || (!prog_req && (timer >= OPEN_LIMIT))) begin
                  state    <= S_IDLE;
                  unlocked <= 1'b0;
                  timer    <= T_ZERO;
               end else if (prog_req) begin
                  state     <= S_PROG;
                  entry     <= 16'h0000;
                  digit_cnt <= 3'd0;
                  timer     <= T_ZERO;
               end else begin
                  timer <= sat_inc(timer);
               end
            end

            S_LOCKOUT: begin
               if (timer >= LOCKOUT_LIMIT) begin
                  state    <= S_IDLE;
                  lockout  <= 1'b0;
                  alarm    <= 1'b0;
                  fail_cnt <= 3'd0;
                  timer    <= T_ZERO;
               end else begin
                  timer <= sat_inc(timer);
               end
            end

            default: begin
               state     <= S_IDLE;
               entry     <= 16'h0000;
               digit_cnt <= 3'd0;
               timer     <= T_ZERO;
               unlocked  <= 1'b0;
               lockout   <= 1'b0;
               alarm     <= 1'b0;
            end
         endcase
      end
   end

endmodule
